// File: rtl/lsu_memory_interface.sv
// Memory-side stage of the LSU: registers one fired load/store, runs a valid/ready
// request to data memory, waits for the response and returns a tagged result pulse.
module lsu_memory_interface #(
   parameter int XLEN     = 32,
   parameter int LDQ_SIZE = 32,
   parameter int STQ_SIZE = 32
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        fire_memory_op,
   input  logic                        memory_op_type,
   input  logic [XLEN-1:0]             memory_address,
   input  logic [XLEN-1:0]             memory_data,
   input  logic [$clog2(LDQ_SIZE)-1:0] load_fired_ldq_index,
   input  logic [$clog2(STQ_SIZE)-1:0] store_fired_index,
   input  logic                        flush,
   output logic                        lsu_ready,
   output logic                        accept,
   output logic                        mem_req_valid,
   input  logic                        mem_req_ready,
   output logic                        mem_req_write,
   output logic [XLEN-1:0]             mem_req_addr,
   output logic [XLEN-1:0]             mem_req_wdata,
   input  logic                        mem_resp_valid,
   input  logic [XLEN-1:0]             mem_resp_rdata,
   output logic                        load_result_valid,
   output logic [$clog2(LDQ_SIZE)-1:0] load_result_ldq_index,
   output logic [XLEN-1:0]             load_result_data,
   output logic                        store_done_valid,
   output logic [$clog2(STQ_SIZE)-1:0] store_done_stq_index
);
   localparam int LDQ_W = $clog2(LDQ_SIZE);
   localparam int STQ_W = $clog2(STQ_SIZE);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   state_t             state_q, state_d;
   logic               write_q, write_d;
   logic [XLEN-1:0]    addr_q, addr_d;
   logic [XLEN-1:0]    wdata_q, wdata_d;
   logic [LDQ_W-1:0]   ldq_idx_q, ldq_idx_d;
   logic [STQ_W-1:0]   stq_idx_q, stq_idx_d;
   logic               killed_q, killed_d;
   logic               ld_valid_q, ld_valid_d;
   logic [LDQ_W-1:0]   ld_idx_q, ld_idx_d;
   logic [XLEN-1:0]    ld_data_q, ld_data_d;
   logic               st_valid_q, st_valid_d;
   logic [STQ_W-1:0]   st_idx_q, st_idx_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         write_q    <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ldq_idx_q  <= '0;
         stq_idx_q  <= '0;
         killed_q   <= 1'b0;
         ld_valid_q <= 1'b0;
         ld_idx_q   <= '0;
         ld_data_q  <= '0;
         st_valid_q <= 1'b0;
         st_idx_q   <= '0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ldq_idx_q  <= ldq_idx_d;
         stq_idx_q  <= stq_idx_d;
         killed_q   <= killed_d;
         ld_valid_q <= ld_valid_d;
         ld_idx_q   <= ld_idx_d;
         ld_data_q  <= ld_data_d;
         st_valid_q <= st_valid_d;
         st_idx_q   <= st_idx_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      write_d       = write_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      ldq_idx_d     = ldq_idx_q;
      stq_idx_d     = stq_idx_q;
      killed_d      = killed_q;
      ld_valid_d    = 1'b0;
      ld_idx_d      = ld_idx_q;
      ld_data_d     = ld_data_q;
      st_valid_d    = 1'b0;
      st_idx_d      = st_idx_q;
      lsu_ready     = 1'b0;
      accept        = 1'b0;
      mem_req_valid = 1'b0;
      case (state_q)
         IDLE: begin
            lsu_ready = 1'b1;
            accept    = fire_memory_op & ~flush;
            if (accept) begin
               write_d  = memory_op_type;
               addr_d   = memory_address;
               wdata_d  = memory_op_type ? memory_data : '0;
               killed_d = 1'b0;
               if (memory_op_type) stq_idx_d = store_fired_index;
               else                ldq_idx_d = load_fired_ldq_index;
               state_d  = REQ;
            end
         end
         REQ: begin
            mem_req_valid = 1'b1;
            if (flush && !write_q) killed_d = 1'b1;
            if (mem_req_ready) state_d = RESP;
         end
         RESP: begin
            if (flush && !write_q) killed_d = 1'b1;
            if (mem_resp_valid) begin
               state_d = IDLE;
               if (write_q) begin
                  st_valid_d = 1'b1;
                  st_idx_d   = stq_idx_q;
               end else if (!killed_q && !flush) begin
                  // a flush coinciding with the response still kills the load
                  ld_valid_d = 1'b1;
                  ld_idx_d   = ldq_idx_q;
                  ld_data_d  = mem_resp_rdata;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign mem_req_write         = write_q;
   assign mem_req_addr          = addr_q;
   assign mem_req_wdata         = wdata_q;
   assign load_result_valid     = ld_valid_q;
   assign load_result_ldq_index = ld_idx_q;
   assign load_result_data      = ld_data_q;
   assign store_done_valid      = st_valid_q;
   assign store_done_stq_index  = st_idx_q;
endmodule

// File: tb/tb_lsu_memory_interface.sv
// Bench for lsu_memory_interface: table vectors, hand sequences and random ops
// checked against a scoreboard of expected result pulses and held outputs.
module tb_lsu_memory_interface;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        fire_memory_op, memory_op_type, flush;
   logic [31:0] memory_address, memory_data, mem_resp_rdata;
   logic [4:0]  load_fired_ldq_index, store_fired_index;
   logic        lsu_ready, accept, mem_req_valid, mem_req_ready, mem_req_write;
   logic [31:0] mem_req_addr, mem_req_wdata, load_result_data;
   logic        mem_resp_valid, load_result_valid, store_done_valid;
   logic [4:0]  load_result_ldq_index, store_done_stq_index;

   lsu_memory_interface #(.XLEN(32), .LDQ_SIZE(32), .STQ_SIZE(32)) dut (
      .clk(clk), .reset_n(reset_n), .fire_memory_op(fire_memory_op),
      .memory_op_type(memory_op_type), .memory_address(memory_address),
      .memory_data(memory_data), .load_fired_ldq_index(load_fired_ldq_index),
      .store_fired_index(store_fired_index), .flush(flush), .lsu_ready(lsu_ready),
      .accept(accept), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
      .mem_resp_rdata(mem_resp_rdata), .load_result_valid(load_result_valid),
      .load_result_ldq_index(load_result_ldq_index), .load_result_data(load_result_data),
      .store_done_valid(store_done_valid), .store_done_stq_index(store_done_stq_index)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // scoreboard: pulses due this cycle and values the held outputs must show
   bit          pend_ld, pend_st;
   logic [4:0]  vis_lidx, vis_sidx;
   logic [31:0] vis_ldata;

   typedef struct {
      bit          st;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] rdata;
      logic [4:0]  idx;
      int          rw;
      int          pw;
      int          fl;
      bit          exp_pulse;
   } vec_t;
   vec_t tbl[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic common_checks();
      chk("load_valid", 32'(load_result_valid), 32'(pend_ld));
      chk("store_valid", 32'(store_done_valid), 32'(pend_st));
      chk("load_idx", 32'(load_result_ldq_index), 32'(vis_lidx));
      chk("load_data", load_result_data, vis_ldata);
      chk("store_idx", 32'(store_done_stq_index), 32'(vis_sidx));
      pend_ld = 1'b0;
      pend_st = 1'b0;
   endtask

   // A load survives unless a flush lands in any REQ or RESP cycle (incl. the response cycle).
   function automatic bit model_pulse(input bit st, input int rw, input int pw, input int fl);
      return st || !(fl >= 1 && fl <= rw + pw + 2);
   endfunction

   task automatic idle_cyc(input bit fl);
      fire_memory_op = fl;
      flush = fl;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      #1;
      chk("idle_ready", 32'(lsu_ready), 32'd1);
      chk("idle_accept", 32'(accept), 32'd0);
      chk("idle_req_valid", 32'(mem_req_valid), 32'd0);
      common_checks();
      step();
      flush = 1'b0;
      fire_memory_op = 1'b0;
   endtask

   // Cycle numbering c is relative to the accept cycle (c=0).
   task automatic run_op(input bit st, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] rdata, input logic [4:0] idx, input int rw,
                         input int pw, input int fl, input bit exp_pulse, input bit hold_fire);
      logic [31:0] exp_wdata;
      exp_wdata = st ? data : 32'd0;
      fire_memory_op = 1'b1;
      memory_op_type = st;
      memory_address = addr;
      memory_data = data;
      load_fired_ldq_index = st ? ~idx : idx;
      store_fired_index = st ? idx : ~idx;
      flush = 1'b0;
      mem_req_ready = 1'b0;
      mem_resp_valid = 1'b0;
      #1;
      chk("accept_ready", 32'(lsu_ready), 32'd1);
      chk("accept", 32'(accept), 32'd1);
      common_checks();
      $display("[TB] op %s idx=%0d addr=0x%08h rw=%0d pw=%0d fl=%0d", st ? "store" : "load",
               idx, addr, rw, pw, fl);
      step();
      if (!hold_fire) fire_memory_op = 1'b0;
      for (int c = 1; c <= rw + pw + 2; c++) begin
         bit in_req;
         in_req = (c <= rw + 1);
         memory_address = $urandom;
         memory_data = $urandom;
         load_fired_ldq_index = 5'($urandom);
         store_fired_index = 5'($urandom);
         flush = (c == fl);
         mem_req_ready = in_req && (c == rw + 1);
         // responses while still in REQ must be ignored
         mem_resp_valid = in_req ? c[0] : (c == rw + pw + 2);
         mem_resp_rdata = (c == rw + pw + 2) ? rdata : $urandom;
         #1;
         chk("busy_ready", 32'(lsu_ready), 32'd0);
         chk("busy_accept", 32'(accept), 32'd0);
         chk("req_valid", 32'(mem_req_valid), 32'(in_req));
         if (in_req) begin
            chk("req_write", 32'(mem_req_write), 32'(st));
            chk("req_addr", mem_req_addr, addr);
            chk("req_wdata", mem_req_wdata, exp_wdata);
         end
         common_checks();
         if (c == rw + pw + 2 && exp_pulse) begin
            if (st) begin
               pend_st = 1'b1;
               vis_sidx = idx;
            end else begin
               pend_ld = 1'b1;
               vis_lidx = idx;
               vis_ldata = rdata;
            end
         end
         step();
      end
      flush = 1'b0;
      mem_resp_valid = 1'b0;
      mem_req_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 5'd5,  0, 1, -1, 1'b1};
      tbl[1] = '{1'b1, 32'h200, 32'h12345678, 32'h0,        5'd3,  4, 0, -1, 1'b1};
      tbl[2] = '{1'b0, 32'h300, 32'h0,        32'h0000AAAA, 5'd9,  0, 2,  3, 1'b0};
      tbl[3] = '{1'b0, 32'h304, 32'h0,        32'h55551234, 5'd7,  1, 0, -1, 1'b1};
      tbl[4] = '{1'b1, 32'h400, 32'hCAFEF00D, 32'h0,        5'd12, 1, 1,  2, 1'b1};
      tbl[5] = '{1'b0, 32'h500, 32'h0,        32'h11112222, 5'd20, 2, 0,  1, 1'b0};
      tbl[6] = '{1'b0, 32'h504, 32'h0,        32'h33334444, 5'd21, 0, 0,  2, 1'b0};
      tbl[7] = '{1'b0, 32'h508, 32'h0,        32'h66667777, 5'd22, 0, 0,  3, 1'b1};

      reset_n = 1'b0;
      fire_memory_op = 1'b0; memory_op_type = 1'b0; flush = 1'b0;
      memory_address = '0; memory_data = '0; mem_resp_rdata = '0;
      load_fired_ldq_index = '0; store_fired_index = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
      pend_ld = 1'b0; pend_st = 1'b0;
      vis_lidx = '0; vis_sidx = '0; vis_ldata = '0;
      #3;
      chk("rst_ready", 32'(lsu_ready), 32'd1);
      chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_req_addr", mem_req_addr, 32'd0);
      common_checks();
      @(negedge clk);
      reset_n = 1'b1;
      step();

      foreach (tbl[i]) begin
         run_op(tbl[i].st, tbl[i].addr, tbl[i].data, tbl[i].rdata, tbl[i].idx,
                tbl[i].rw, tbl[i].pw, tbl[i].fl, tbl[i].exp_pulse, 1'b0);
         idle_cyc(tbl[i].fl == tbl[i].rw + tbl[i].pw + 3);
      end

      // fire while flushing in IDLE is refused
      idle_cyc(1'b1);
      idle_cyc(1'b0);

      // back-to-back with fire held high
      run_op(1'b0, 32'h600, 32'h0, 32'hB0B0B0B0, 5'd1, 0, 0, -1, 1'b1, 1'b1);
      run_op(1'b1, 32'h604, 32'h0F0F0F0F, 32'h0, 5'd2, 0, 0, -1, 1'b1, 1'b1);
      idle_cyc(1'b0);

      for (int n = 0; n < 40; n++) begin
         bit st;
         int rw, pw, fl;
         st = 1'($urandom_range(0, 1));
         rw = int'($urandom_range(0, 3));
         pw = int'($urandom_range(0, 3));
         fl = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 32'(rw + pw + 3))) : -1;
         run_op(st, $urandom, $urandom, $urandom, 5'($urandom), rw, pw, fl,
                model_pulse(st, rw, pw, fl), 1'b0);
         if (fl == rw + pw + 3 || $urandom_range(0, 1) == 1) idle_cyc(fl == rw + pw + 3);
      end
      idle_cyc(1'b0);

      // reset while in REQ abandons the op
      fire_memory_op = 1'b1; memory_op_type = 1'b0; flush = 1'b0;
      memory_address = 32'h700; load_fired_ldq_index = 5'd9;
      #1;
      chk("pre_rst_accept", 32'(accept), 32'd1);
      common_checks();
      step();
      fire_memory_op = 1'b0;
      #1;
      chk("pre_rst_req_valid", 32'(mem_req_valid), 32'd1);
      reset_n = 1'b0;
      #1;
      pend_ld = 1'b0; pend_st = 1'b0;
      vis_lidx = '0; vis_sidx = '0; vis_ldata = '0;
      chk("mid_rst_req_valid", 32'(mem_req_valid), 32'd0);
      chk("mid_rst_ready", 32'(lsu_ready), 32'd1);
      chk("mid_rst_addr", mem_req_addr, 32'd0);
      chk("mid_rst_write", 32'(mem_req_write), 32'd0);
      common_checks();
      @(negedge clk);
      reset_n = 1'b1;
      step();
      for (int k = 0; k < 3; k++) begin
         mem_resp_valid = 1'b1;
         mem_resp_rdata = 32'hFFFF0000;
         #1;
         chk("post_rst_ready", 32'(lsu_ready), 32'd1);
         chk("post_rst_req_valid", 32'(mem_req_valid), 32'd0);
         common_checks();
         step();
      end
      mem_resp_valid = 1'b0;
      idle_cyc(1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/lsu_memory_interface.md
Name: lsu_memory_interface

Overview:
Sits directly downstream of lsu_control and registers the single memory op it fires each cycle. Drives a valid/ready request channel to the data memory and waits for the response. Returns load data, tagged with its LDQ index, to the load queue, and signals store completion, tagged with its STQ index, to the store queue. Holds one outstanding op at a time and back-pressures lsu_control through lsu_ready/accept.

Parameters:
XLEN, 32, data/address width
LDQ_SIZE, 32, load queue entries; index width $clog2(LDQ_SIZE)
STQ_SIZE, 32, store queue entries; index width $clog2(STQ_SIZE)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
fire_memory_op  input  1  lsu_control requests an op this cycle
memory_op_type  input  1  0=load, 1=store
memory_address  input  XLEN  op address
memory_data  input  XLEN  store data
load_fired_ldq_index  input  $clog2(LDQ_SIZE)  LDQ index of the fired load
store_fired_index  input  $clog2(STQ_SIZE)  STQ index of the fired store
flush  input  1  pipeline flush; kills any in-flight load
lsu_ready  output  1  block is in IDLE and can take an op
accept  output  1  op captured this cycle; LDQ/STQ set executed only when high
mem_req_valid  output  1  request valid
mem_req_ready  input  1  memory accepts request
mem_req_write  output  1  1=store
mem_req_addr  output  XLEN  request address
mem_req_wdata  output  XLEN  store data; 0 for loads
mem_resp_valid  input  1  response for the outstanding request
mem_resp_rdata  input  XLEN  load data
load_result_valid  output  1  one-cycle pulse: load data returned
load_result_ldq_index  output  $clog2(LDQ_SIZE)  LDQ entry of the result
load_result_data  output  XLEN  loaded data
store_done_valid  output  1  one-cycle pulse: store written
store_done_stq_index  output  $clog2(STQ_SIZE)  STQ entry completed

Behaviour:
- Reset (async, reset_n=0): state=IDLE. All outputs and internal registers are 0, except lsu_ready, which is combinational and reads 1 in IDLE. Reset mid-operation abandons the op; no result pulse.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - lsu_ready=1.
  - accept = fire_memory_op & ~flush (combinational).
  - On accept, latch type, address, data (forced to 0 for loads) and the relevant index; clear killed; next state REQ.
  - fire_memory_op while flush is high is not accepted.
- REQ:
  - mem_req_valid=1; write/addr/wdata are driven from the latched registers and held stable until the handshake.
  - On mem_req_valid & mem_req_ready, go to RESP.
  - Valid is never withdrawn, including on flush.
- RESP:
  - mem_req_valid=0. Wait for mem_resp_valid, which may arrive at any latency ≥1 cycle after the handshake.
  - On mem_resp_valid, go to IDLE and register the result:
    - Load with killed=0: next cycle load_result_valid=1, load_result_ldq_index=latched index, load_result_data=mem_resp_rdata.
    - Store: next cycle store_done_valid=1, store_done_stq_index=latched index.
    - Load with killed=1: no pulse.
- Result pulses last exactly one cycle. Index and data outputs hold their last value between pulses.
- Kill rules:
  - flush in REQ or RESP with a latched load sets killed=1.
  - flush in the same cycle as mem_resp_valid for a load suppresses the pulse.
  - A flush in the cycle after the response has already been registered does not cancel the pulse; the LDQ discards it.
- Stores are committed and are never killed by flush.
- mem_resp_valid outside RESP is ignored.
- Throughput: at most one op in flight. Minimum loop is 3 cycles per op: accept, REQ with ready=1, RESP with immediate response. The next accept is possible in the cycle the result pulse is visible.
- lsu_ready=0 in REQ and RESP. lsu_control must keep fire_memory_op pending but must not mark entries executed without accept.

Test Plan:
1. Load, addr=0x100, ldq idx=5; mem_req_ready=1 immediately; resp 2 cycles later, rdata=0xDEADBEEF -> mem_req_write=0, mem_req_wdata=0; one-cycle load_result_valid with idx=5, data=0xDEADBEEF; lsu_ready returns to 1.
2. Store, addr=0x200, data=0x12345678, stq idx=3; mem_req_ready held low 4 cycles -> valid/addr/wdata stable all 4 cycles; after resp, store_done_valid pulse with idx=3; no load pulse.
3. Load accepted, then flush asserted while in RESP; resp rdata=0xAAAA -> no load_result_valid; state returns to IDLE; next load, idx=7, completes normally.
4. Store in flight plus flush -> store_done_valid still pulses with the correct idx. fire_memory_op with flush=1 in IDLE -> accept=0, state stays IDLE.
5. Back-to-back ops: load idx=1 then store idx=2, with fire held high and immediate ready/resp -> accept high only in IDLE cycles; results arrive in order; no op is lost or duplicated.
6. reset_n driven low while in REQ -> all outputs 0 immediately, lsu_ready=1 once in IDLE; a later resp is ignored and no pulse occurs.
